// File: rtl/mux_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux_rr_arbiter
//   Round-robin arbiter in front of a shared single-consumer datapath. One
//   requester wins each transfer. Its payload is captured into a one-entry
//   registered output stage. The winning index is exported so that downstream
//   steering logic can reuse it.
//
// Parameters
//   N_REQ  : number of requesters (>= 2, any value, not only powers of 2)
//   DWIDTH : payload width in bits
//   SELW   : index width, fixed at $clog2(N_REQ)
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   req_valid  in   [N_REQ]       requester i has data
//   req_data   in   [DWIDTH] x N  payload per requester (unpacked array)
//   req_ready  out  [N_REQ]       one-hot or zero, requester i transferred
//   out_valid  out  1             output register holds data
//   out_ready  in   1             consumer accepts output
//   out_data   out  [DWIDTH]      registered payload
//   out_sel    out  [SELW]        index of requester whose payload is held
// -----------------------------------------------------------------------------
module mux_rr_arbiter #(
  parameter int N_REQ  = 4,
  parameter int DWIDTH = 8,
  localparam int SELW  = $clog2(N_REQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_REQ-1:0]  req_valid,
  input  logic [DWIDTH-1:0] req_data [N_REQ],
  output logic [N_REQ-1:0]  req_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] out_data,
  output logic [SELW-1:0]   out_sel
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  // One extra bit so that last + k (k <= N_REQ) never overflows before the wrap.
  localparam logic [SELW:0]   N_EXT    = (SELW+1)'(N_REQ);
  localparam logic [SELW-1:0] LAST_RST = SELW'(N_REQ - 1);

  state_t          state_r;
  state_t          state_n;
  logic [SELW-1:0] last_r;
  logic [SELW-1:0] winner_s;
  logic            load_s;

  // Round-robin search. Offsets are walked from farthest to nearest so that the
  // nearest valid requester after last_r is written last and wins. The wrap is
  // an explicit subtract, which keeps non-power-of-2 counts correct.
  always_comb begin
    logic [SELW:0] cand_v;
    winner_s = '0;
    cand_v   = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      cand_v   = {1'b0, last_r} + (SELW+1)'(k);
      cand_v   = (cand_v >= N_EXT) ? (cand_v - N_EXT) : cand_v;
      winner_s = req_valid[cand_v[SELW-1:0]] ? cand_v[SELW-1:0] : winner_s;
    end
  end

  // A transfer happens when the output slot is free or draining this cycle.
  // rst_n gates the load so that no requester sees a grant while in reset.
  assign load_s = rst_n & (~out_valid | out_ready) & (|req_valid);

  // Grant goes only to the winner, and only on a load.
  always_comb begin
    req_ready = '0;
    if (load_s) begin
      req_ready[winner_s] = 1'b1;
    end else begin
      req_ready = '0;
    end
  end

  // Output-slot occupancy. A load while FULL is a simultaneous drain and refill.
  always_comb begin
    state_n = state_r;
    case (state_r)
      EMPTY: begin
        if (load_s) begin
          state_n = FULL;
        end else begin
          state_n = EMPTY;
        end
      end
      FULL: begin
        if (load_s) begin
          state_n = FULL;
        end else if (out_ready) begin
          state_n = EMPTY;
        end else begin
          state_n = FULL;
        end
      end
      default: state_n = EMPTY;
    endcase
  end

  // State, output register and round-robin pointer. out_data and out_sel keep
  // their last values when the slot drains without a refill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= EMPTY;
      out_data <= '0;
      out_sel  <= '0;
      last_r   <= LAST_RST;
    end else begin
      state_r <= state_n;
      if (load_s) begin
        out_data <= req_data[winner_s];
        out_sel  <= winner_s;
        last_r   <= winner_s;
      end
    end
  end

  assign out_valid = (state_r == FULL);

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mux_rr_arbiter
//   Self-checking bench for mux_rr_arbiter. Drives a 4-requester instance and a
//   3-requester instance side by side. Both are compared every cycle against a
//   behavioural model. The model holds the output slot as plain variables and
//   picks winners by scanning last+1, last+2, ... modulo n.
// -----------------------------------------------------------------------------
module tb_mux_rr_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // 4-requester instance
  logic [3:0] rv4, rr4;
  logic [7:0] rd4 [4];
  logic       or4, ov4;
  logic [7:0] od4;
  logic [1:0] os4;

  // 3-requester instance
  logic [2:0] rv3, rr3;
  logic [7:0] rd3 [3];
  logic       or3, ov3;
  logic [7:0] od3;
  logic [1:0] os3;

  mux_rr_arbiter #(.N_REQ(4), .DWIDTH(8)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .req_valid(rv4), .req_data(rd4), .req_ready(rr4),
    .out_valid(ov4), .out_ready(or4), .out_data(od4), .out_sel(os4)
  );

  mux_rr_arbiter #(.N_REQ(3), .DWIDTH(8)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(rv3), .req_data(rd3), .req_ready(rr3),
    .out_valid(ov3), .out_ready(or3), .out_data(od3), .out_sel(os3)
  );

  int checks = 0;
  int errors = 0;

  // Model state: slot contents and pointer for each instance
  logic       m4_v, m3_v;
  logic [7:0] m4_d, m3_d;
  int         m4_s, m3_s, m4_last, m3_last;
  logic [3:0] g4;
  logic [2:0] g3;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // First valid index in the order last+1, last+2, ... (mod n); -1 if none
  function automatic int rr_pick(input int n, input int last, input logic [3:0] v);
    for (int k = 1; k <= n; k++) begin
      int idx;
      idx = (last + k) % n;
      if (((v >> idx) & 4'd1) != 4'd0) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m4_v = 1'b0; m4_d = 8'h00; m4_s = 0; m4_last = 3;
    m3_v = 1'b0; m3_d = 8'h00; m3_s = 0; m3_last = 2;
    g4 = 4'b0; g3 = 3'b0;
  endtask

  // One clock cycle. The caller has already driven the inputs. This task checks
  // the grants, advances the model across the edge, then checks the outputs.
  task automatic step();
    int   w4, w3;
    logic l4, l3;
    #1;
    w4 = rr_pick(4, m4_last, rv4);
    w3 = rr_pick(3, m3_last, {1'b0, rv3});
    l4 = (!m4_v || or4) && (rv4 != 4'b0);
    l3 = (!m3_v || or3) && (rv3 != 3'b0);
    g4 = l4 ? 4'(1 << w4) : 4'b0;
    g3 = l3 ? 3'(1 << w3) : 3'b0;
    check("req_ready4", 32'(rr4), 32'(g4));
    check("req_ready3", 32'(rr3), 32'(g3));
    @(posedge clk);
    if (l4) begin
      m4_v = 1'b1; m4_d = rd4[w4]; m4_s = w4; m4_last = w4;
    end else if (m4_v && or4) begin
      m4_v = 1'b0;
    end
    if (l3) begin
      m3_v = 1'b1; m3_d = rd3[w3]; m3_s = w3; m3_last = w3;
    end else if (m3_v && or3) begin
      m3_v = 1'b0;
    end
    #1;
    check("out_valid4", 32'(ov4), 32'(m4_v));
    check("out_data4",  32'(od4), 32'(m4_d));
    check("out_sel4",   32'(os4), 32'(m4_s));
    check("out_valid3", 32'(ov3), 32'(m3_v));
    check("out_data3",  32'(od3), 32'(m3_d));
    check("out_sel3",   32'(os3), 32'(m3_s));
  endtask

  // Random requester behaviour for the 3-requester instance. A requester holds
  // valid and data until it is granted, and may raise a new request afterwards.
  task automatic rand3();
    for (int i = 0; i < 3; i++) begin
      if (g3[i]) rv3[i] = 1'b0;
      if (!rv3[i] && ($urandom_range(0, 1) == 1)) begin
        rv3[i] = 1'b1;
        rd3[i] = 8'($urandom);
      end
    end
    or3 = ($urandom_range(0, 3) != 0);
  endtask

  // The same behaviour for the 4-requester instance.
  task automatic rand4();
    for (int i = 0; i < 4; i++) begin
      if (g4[i]) rv4[i] = 1'b0;
      if (!rv4[i] && ($urandom_range(0, 2) == 0)) begin
        rv4[i] = 1'b1;
        rd4[i] = 8'($urandom);
      end
    end
    or4 = ($urandom_range(0, 3) != 0);
  endtask

  initial begin
    rst_n = 1'b0;
    rv4 = 4'b1111; or4 = 1'b1;
    rv3 = 3'b101;  or3 = 1'b1;
    for (int i = 0; i < 4; i++) rd4[i] = 8'h10 + 8'(i);
    for (int i = 0; i < 3; i++) rd3[i] = 8'h20 + 8'(i);
    model_reset();

    // Reset state, with requests present
    @(posedge clk); @(posedge clk); #1;
    check("rst_out_valid4", 32'(ov4), 32'd0);
    check("rst_out_data4",  32'(od4), 32'd0);
    check("rst_out_sel4",   32'(os4), 32'd0);
    check("rst_req_ready4", 32'(rr4), 32'd0);
    check("rst_req_ready3", 32'(rr3), 32'd0);
    rst_n = 1'b1;

    // All four valid with 0x10..0x13: strict rotation 0,1,2,3,0...
    // The 3-requester instance starts with pointer 2 and requests on 0 and 2,
    // so the wrap must give requester 0.
    for (int i = 0; i < 8; i++) begin
      step();
      check("rot_data", 32'(od4), 32'(8'h10 + 8'(i % 4)));
      check("rot_sel",  32'(os4), 32'(i % 4));
      if (i == 0) check("wrap3_sel", 32'(os3), 32'd0);
      rand3();
    end

    // Drain the slot, then only requester 2 valid (0xA5) while out_ready is low
    rv4 = 4'b0000; or4 = 1'b1; step(); rand3();
    rv4 = 4'b0100; rd4[2] = 8'hA5; or4 = 1'b0; step(); rand3();
    check("hold_valid", 32'(ov4), 32'd1);
    check("hold_data",  32'(od4), 32'hA5);
    rv4 = 4'b0000;
    for (int i = 0; i < 2; i++) begin
      step(); rand3();
      check("hold_data_held", 32'(od4), 32'hA5);
    end
    or4 = 1'b1; step(); rand3();
    check("drain_valid", 32'(ov4), 32'd0);

    // Set the pointer to 1, then request 0 and 3: 3 wins, then 0
    rv4 = 4'b0001; step(); rand3();
    rv4 = 4'b0010; step(); rand3();
    rv4 = 4'b1001; step(); rand3();
    check("last1_first", 32'(os4), 32'd3);
    rv4 = 4'b0001; step(); rand3();
    check("last1_second", 32'(os4), 32'd0);

    // Backpressure toggle with all valid. A granted requester presents new data.
    rv4 = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      or4 = (i % 2 == 0);
      step(); rand3();
      for (int j = 0; j < 4; j++) if (g4[j]) rd4[j] = 8'($urandom);
    end

    // Reset while FULL with 0x33
    rv4 = 4'b0000; or4 = 1'b1; step(); rand3();
    rv4 = 4'b0010; rd4[1] = 8'h33; or4 = 1'b0; step(); rand3();
    rv4 = 4'b0000; step(); rand3();
    check("pre_rst_data", 32'(od4), 32'h33);
    #2;
    rst_n = 1'b0; rv4 = 4'b1111;
    #1;
    check("async_rst_valid", 32'(ov4), 32'd0);
    check("async_rst_data",  32'(od4), 32'd0);
    check("async_rst_ready", 32'(rr4), 32'd0);
    model_reset();
    @(posedge clk); #1;
    check("held_rst_valid", 32'(ov4), 32'd0);
    check("held_rst_ready3", 32'(rr3), 32'd0);
    rst_n = 1'b1; or4 = 1'b1;
    step(); rand3();
    check("post_rst_sel", 32'(os4), 32'd0);

    // Long randomized run on both instances
    for (int i = 0; i < 400; i++) begin
      rand4(); rand3();
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_rr_arbiter.md
# mux_rr_arbiter

Round-robin arbiter that shares one `DWIDTH`-bit datapath among `N_REQ` requesters using valid/ready handshakes. It picks one winner per transfer, selects the winner's data internally, and presents it on a one-entry registered output stage. The block sits in front of any shared single-consumer resource in the core, for example a shared memory port or a shared writeback path. It also exports the winning index so downstream steering muxes can reuse it.

## Interface
- `N_REQ`, default 4: number of requesters; must be ≥ 2; any value is legal, not only powers of 2.
- `DWIDTH`, default 8: payload width in bits.
- `SELW`, derived and not overridable: `$clog2(N_REQ)`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in `[N_REQ]`: requester i has data.
- `req_data` in `[DWIDTH-1:0] [N_REQ]` (unpacked array): payload per requester.
- `req_ready` out `[N_REQ]`: one-hot or zero; requester i transferred this cycle.
- `out_valid` out 1: output register holds data.
- `out_ready` in 1: consumer accepts output.
- `out_data` out `DWIDTH`: registered payload.
- `out_sel` out `SELW`: index of the requester whose payload is in `out_data`.

## Operation
- States (1-bit FSM):
  - EMPTY: `out_valid`=0.
  - FULL: `out_valid`=1.
- Load enable: `load = (~out_valid | out_ready) & |req_valid`.
- Winner selection uses the round-robin pointer `last`, which holds the last granted index.
  - Search order is `last+1, last+2, …`, wrapping modulo `N_REQ` (non-power-of-2 wrap is explicit, e.g. N_REQ=3: 2→0).
  - The winner is the first index in that order with `req_valid`=1.
  - Selection is combinational and recomputed every cycle.
- `req_ready[winner]` = `load`; all other `req_ready` bits are 0. `req_ready` depends combinationally on `req_valid`, `out_valid` and `out_ready`; it never depends on `req_ready` itself.
- On a `load` edge:
  - `out_data` ← `req_data[winner]`, `out_sel` ← winner, `last` ← winner.
  - Next state is FULL.
- On an `out_valid & out_ready & ~load` edge: next state is EMPTY. `out_data` and `out_sel` keep their values.
- FULL with `out_ready`=0: `out_data`, `out_sel` and `last` all hold. No `req_ready` is asserted. Requesters must hold `req_valid` and `req_data` stable until granted.
- Simultaneous drain and load: the old word leaves, the new word is captured in the same cycle, and the state stays FULL. This gives full throughput, one transfer per cycle.
- No requester is granted twice while another valid requester waits, so worst-case wait is `N_REQ-1` transfers.
- `req_valid` deasserting before grant (protocol violation): it is simply not considered. There is no error output.

## Timing
- Reset values, applied asynchronously on `rst_n`=0:
  - `out_valid`=0, `out_data`=0, `out_sel`=0.
  - `last`=`N_REQ-1`, so requester 0 has first priority.
  - FSM=EMPTY.
  - `req_ready`=0 while in reset.
- Reset removal is synchronous to `clk` (synchronized externally); the first grant can occur on the first edge after deassertion.
- Latency: request accepted at edge n → `out_valid`=1 with data from cycle n+1.
- Throughput: 1 word/cycle while `out_ready`=1 and any request is pending.
- Reset mid-operation: a FULL word is discarded, `last` returns to `N_REQ-1`, and no partial handshake survives.
- `out_*` are driven directly from flops. `req_ready` is combinational.

## Test plan
- Reset, all 4 requests valid with data 0x10/0x11/0x12/0x13, `out_ready`=1 → outputs 0x10,0x11,0x12,0x13,0x10… on consecutive cycles, `out_sel` 0,1,2,3,0; exactly one `req_ready` bit high each cycle.
- Only requester 2 valid (0xA5), `out_ready`=0 for 3 cycles → `out_valid` 1 from the cycle after the request, `out_data`=0xA5 held; `req_ready[2]` high only in the first cycle. Raising `out_ready` → `out_valid` drops the next cycle.
- `last`=1, requests on 0 and 3 → 3 wins, then 0. N_REQ=3 instance with `last`=2 and requests on 0 and 2 → 0 wins (wrap).
- Backpressure toggle (`out_ready` 1,0,1,0) with all requests valid → no word lost or duplicated; grant order stays strictly round-robin.
- Assert `rst_n`=0 mid-stream while FULL (data 0x33) → `out_valid`=0 immediately and `out_data`=0. After release, requester 0 wins first.
